// File: rtl/tt_um_nibble_packer_fifo_pkg.sv
// tt_um_nibble_packer_fifo_pkg: shared pairing-state type, default sizes and widths
package tt_um_nibble_packer_fifo_pkg;
   typedef enum logic {LOW_WAIT, HIGH_WAIT} pair_state_t;
   localparam int DEPTH_DEF   = 4;
   localparam int TIMEOUT_DEF = 255;
   localparam int CORR_W      = 8;
endpackage

// File: rtl/tt_um_nibble_packer_fifo_if.sv
// tt_um_nibble_packer_fifo_if: nibble input, consumer pop and status bundle
interface tt_um_nibble_packer_fifo_if;
   import tt_um_nibble_packer_fifo_pkg::*;
   logic              nib_valid;
   logic [3:0]        nib_data;
   logic [2:0]        nib_syndrome;
   logic              rd_en;
   logic [7:0]        byte_out;
   logic              byte_err;
   logic              byte_valid;
   logic              full;
   logic              pair_pending;
   logic              overflow;
   logic [CORR_W-1:0] corr_count;
   modport master (
      output nib_valid, nib_data, nib_syndrome, rd_en,
      input  byte_out, byte_err, byte_valid, full, pair_pending, overflow, corr_count
   );
   modport slave (
      input  nib_valid, nib_data, nib_syndrome, rd_en,
      output byte_out, byte_err, byte_valid, full, pair_pending, overflow, corr_count
   );
endinterface

// File: rtl/tt_um_sync_fifo_9b.sv
// tt_um_sync_fifo_9b: show-ahead FIFO of {err, byte} entries with extra-MSB pointers
module tt_um_sync_fifo_9b #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [8:0] din,
   input  logic       pop,
   output logic [8:0] dout,
   output logic       empty,
   output logic       full
);
   localparam int AW = $clog2(DEPTH);
   logic [8:0]  mem [DEPTH];
   logic [AW:0] wp, rp;
   logic        do_pop, do_push;
   assign empty   = wp == rp;
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_pop  = pop && !empty;
   // a pop frees the head slot, so a full FIFO still accepts a same-cycle push
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rp[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         wp <= wp + {{AW{1'b0}}, do_push};
         rp <= rp + {{AW{1'b0}}, do_pop};
      end
   always_ff @(posedge clk)
      if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/tt_um_nibble_packer_fifo.sv
// tt_um_nibble_packer_fifo: pairs decoded nibbles into bytes and queues them with an error flag
// NIBBLE_PACKER_CORR_STATS_EN adds a saturating corrected-nibble counter on corr_count
module tt_um_nibble_packer_fifo
   import tt_um_nibble_packer_fifo_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic                      clk,
   input logic                      rst_n,
   input logic                      ena,
   tt_um_nibble_packer_fifo_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 2);
   pair_state_t state, state_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic [3:0]    held;
   logic          held_err, ovf, take, pop, push, nib_err;
   logic          fifo_empty, fifo_full;
   logic [8:0]    fifo_dout;
   assign take    = ena && bus.nib_valid;
   assign pop     = ena && bus.rd_en;
   assign nib_err = bus.nib_syndrome != 3'd0;
   // a partner nibble takes priority over the timeout firing in the same cycle
   always_comb begin
      state_nx = state;
      tcnt_nx  = '0;
      push     = 1'b0;
      if (state == LOW_WAIT) begin
         state_nx = take ? HIGH_WAIT : LOW_WAIT;
      end else if (take) begin
         push     = 1'b1;
         state_nx = LOW_WAIT;
      end else if (!ena || TIMEOUT == 0) begin
         tcnt_nx = tcnt;
      end else if (tcnt == TW'(TIMEOUT - 1)) begin
         state_nx = LOW_WAIT;
      end else begin
         tcnt_nx = tcnt + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= LOW_WAIT;
         tcnt     <= '0;
         held     <= '0;
         held_err <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         state <= state_nx;
         tcnt  <= tcnt_nx;
         if (state == LOW_WAIT && take) begin
            held     <= bus.nib_data;
            held_err <= nib_err;
         end
         if (push && fifo_full && !pop) ovf <= 1'b1;
      end
   tt_um_sync_fifo_9b #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({held_err | nib_err, bus.nib_data, held}),
      .pop   (pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );
   assign bus.byte_out     = fifo_dout[7:0];
   assign bus.byte_err     = fifo_dout[8];
   assign bus.byte_valid   = !fifo_empty;
   assign bus.full         = fifo_full;
   assign bus.pair_pending = state == HIGH_WAIT;
   assign bus.overflow     = ovf;
`ifdef NIBBLE_PACKER_CORR_STATS_EN
   logic [CORR_W-1:0] corr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) corr <= '0;
      else if (take && nib_err && corr != '1) corr <= corr + 1'b1;
   assign bus.corr_count = corr;
`else
   assign bus.corr_count = '0;
`endif
endmodule

// File: tb/tb_tt_um_nibble_packer_fifo.sv
// tb_tt_um_nibble_packer_fifo: scoreboard bench for pairing, FIFO, overflow, timeout and reset
module tb_tt_um_nibble_packer_fifo;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 10;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [8:0] sb [$];
   logic       m_pend = 1'b0;
   logic [3:0] m_held = '0;
   logic       m_herr = 1'b0;
   logic       m_ovf = 1'b0;
   int         m_tc = 0;
   int         m_cc = 0;
   tt_um_nibble_packer_fifo_if bus ();
   tt_um_nibble_packer_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_outputs(input string tag);
      logic [8:0] head;
      int         cc_exp;
      head = sb.size() != 0 ? sb[0] : 9'h0;
`ifdef NIBBLE_PACKER_CORR_STATS_EN
      cc_exp = m_cc;
`else
      cc_exp = 0;
`endif
      check({tag, ".byte_valid"},   32'(bus.byte_valid),   32'(sb.size() != 0));
      check({tag, ".byte_out"},     32'(bus.byte_out),     32'(head[7:0]));
      check({tag, ".byte_err"},     32'(bus.byte_err),     32'(head[8]));
      check({tag, ".full"},         32'(bus.full),         32'(sb.size() == DEPTH));
      check({tag, ".pair_pending"}, 32'(bus.pair_pending), 32'(m_pend));
      check({tag, ".overflow"},     32'(bus.overflow),     32'(m_ovf));
      check({tag, ".corr_count"},   32'(bus.corr_count),   32'(cc_exp));
   endtask
   // one clock with the given inputs; the model follows the specified behaviour
   task automatic drive(input string tag, input logic en, input logic nv, input logic [3:0] d,
                        input logic [2:0] s, input logic rd);
      logic [8:0] popped;
      if (en && rd && sb.size() != 0) check({tag, ".pop_head"}, 32'({bus.byte_err, bus.byte_out}), 32'(sb[0]));
      ena = en;
      bus.nib_valid = nv;
      bus.nib_data = d;
      bus.nib_syndrome = s;
      bus.rd_en = rd;
      @(posedge clk);
      @(negedge clk);
      ena = 1'b1;
      bus.nib_valid = 1'b0;
      bus.rd_en = 1'b0;
      if (en) begin
         if (rd && sb.size() != 0) popped = sb.pop_front();
         if (nv) begin
            if (s != 3'd0 && m_cc < 255) m_cc++;
            if (m_pend) begin
               if (sb.size() < DEPTH) sb.push_back({m_herr | (s != 3'd0), d, m_held});
               else m_ovf = 1'b1;
               m_pend = 1'b0;
            end else begin
               m_pend = 1'b1;
               m_held = d;
               m_herr = s != 3'd0;
               m_tc = 0;
            end
         end else if (m_pend) begin
            m_tc++;
            if (m_tc == TIMEOUT) m_pend = 1'b0;
         end
      end
      check_outputs(tag);
   endtask
   task automatic model_reset();
      sb.delete();
      m_pend = 1'b0;
      m_ovf = 1'b0;
      m_tc = 0;
      m_cc = 0;
   endtask
   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      bus.nib_valid = 1'b0;
      bus.nib_data = '0;
      bus.nib_syndrome = '0;
      bus.rd_en = 1'b0;
      @(negedge clk);
      check_outputs("por");
      rst_n = 1'b1;
      ena = 1'b1;
      // pairing and one-cycle latency
      drive("p_lo", 1, 1, 4'h5, 0, 0);
      drive("p_hi", 1, 1, 4'hA, 0, 0);
      check("p_byte", 32'(bus.byte_out), 32'hA5);
      drive("p_pop", 1, 0, 0, 0, 1);
      // error flag and correction count
      drive("e_lo", 1, 1, 4'h3, 3, 0);
      drive("e_hi", 1, 1, 4'hC, 0, 0);
      check("e_err", 32'(bus.byte_err), 32'h1);
      drive("e_pop", 1, 0, 0, 0, 1);
      drive("e_hi_err", 1, 1, 4'h1, 0, 0);
      drive("e_hi_err2", 1, 1, 4'h2, 5, 0);
      drive("e_pop2", 1, 0, 0, 0, 1);
      // ena low ignores nibbles and pops
      drive("ena_lo", 1, 1, 4'hE, 0, 0);
      drive("ena_off", 0, 1, 4'hF, 1, 1);
      drive("ena_hi", 1, 1, 4'hD, 0, 0);
      drive("ena_off_pop", 0, 0, 0, 0, 1);
      drive("ena_pop", 1, 0, 0, 0, 1);
      // full with simultaneous pop: no overflow, order kept
      for (int i = 0; i < DEPTH; i++) begin
         drive("f_lo", 1, 1, 4'(i), 0, 0);
         drive("f_hi", 1, 1, 4'(i + 8), 0, 0);
      end
      drive("f_lo5", 1, 1, 4'h9, 0, 0);
      drive("f_pushpop", 1, 1, 4'h6, 0, 1);
      for (int i = 0; i < DEPTH; i++) drive("f_drain", 1, 0, 0, 0, 1);
      // overflow: fifth byte dropped, sticky flag
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive("o_lo", 1, 1, 4'(i + 3), 0, 0);
         drive("o_hi", 1, 1, 4'(15 - i), 0, 0);
      end
      check("o_full", 32'(bus.full), 32'h1);
      check("o_ovf", 32'(bus.overflow), 32'h1);
      for (int i = 0; i < DEPTH; i++) drive("o_drain", 1, 0, 0, 0, 1);
      drive("o_empty_rd", 1, 0, 0, 0, 1);
      // timeout with an ena-low freeze in the middle
      drive("t_lo", 1, 1, 4'h7, 0, 0);
      for (int i = 0; i < 5; i++) drive("t_wait", 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive("t_freeze", 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive("t_wait2", 1, 0, 0, 0, 0);
      check("t_dropped", 32'(bus.pair_pending), 32'h0);
      drive("t_n1", 1, 1, 4'h1, 0, 0);
      drive("t_n2", 1, 1, 4'h2, 0, 0);
      check("t_byte", 32'(bus.byte_out), 32'h21);
      drive("t_pop", 1, 0, 0, 0, 1);
      // partner arriving on the timeout cycle is paired
      drive("te_lo", 1, 1, 4'h4, 0, 0);
      for (int i = 0; i < TIMEOUT - 1; i++) drive("te_wait", 1, 0, 0, 0, 0);
      drive("te_hi", 1, 1, 4'h8, 0, 0);
      check("te_byte", 32'(bus.byte_out), 32'h84);
      // reset mid-pair with bytes queued
      drive("r_lo", 1, 1, 4'hB, 0, 0);
      drive("r_hi", 1, 1, 4'h3, 0, 0);
      drive("r_pend", 1, 1, 4'hF, 2, 0);
      do_reset();
      drive("r_empty_rd", 1, 0, 0, 0, 1);
      drive("r_lo2", 1, 1, 4'h6, 0, 0);
      drive("r_hi2", 1, 1, 4'h9, 0, 0);
      check("r_byte", 32'(bus.byte_out), 32'h96);
      drive("r_pop", 1, 0, 0, 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
